// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl
// Run controller for the Smith-Waterman systolic PE array. A run loads
// PE_LENGTH query symbols into the PEs, streams t_len target symbols through
// the array, counts the beats leaving the array while tracking the running
// maximum of the array's max output, and returns that maximum as the
// local-alignment score over a valid/ready result port.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, t_len        run request and target length, sampled in IDLE
//   q_valid/q_ready     query symbol handshake, q_sym symbol
//   t_valid/t_ready     target symbol handshake, t_sym symbol
//   res_valid/res_ready result handshake, res_score final score
//   busy                high in every state except IDLE
//   arr_s, arr_s_load   query broadcast and shift enable into the PEs
//   arr_t, arr_valid    target symbol and valid_in of the array
//   arr_v, arr_f, arr_max  array boundary inputs, tied to zero
//   arr_valid_out, arr_max_out  array output beat and its max score
module sw_array_ctrl #(
   parameter int PE_LENGTH = 128,
   parameter int LEN_W     = 12,
   parameter int SCORE_W   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   t_len,
   input  logic               q_valid,
   output logic               q_ready,
   input  logic [1:0]         q_sym,
   input  logic               t_valid,
   output logic               t_ready,
   input  logic [1:0]         t_sym,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [SCORE_W-1:0] res_score,
   output logic               busy,
   output logic [1:0]         arr_s,
   output logic               arr_s_load,
   output logic [1:0]         arr_t,
   output logic               arr_valid,
   output logic [SCORE_W-1:0] arr_v,
   output logic [SCORE_W-1:0] arr_f,
   output logic [SCORE_W-1:0] arr_max,
   input  logic               arr_valid_out,
   input  logic [SCORE_W-1:0] arr_max_out
);

   localparam int Q_W = $clog2(PE_LENGTH);
   localparam logic [Q_W-1:0] Q_LAST = Q_W'(PE_LENGTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [LEN_W-1:0]   len_r;
   logic [Q_W-1:0]     q_cnt_r;
   logic [LEN_W-1:0]   t_cnt_r;
   logic [LEN_W-1:0]   o_cnt_r;
   logic [SCORE_W-1:0] max_r;
   logic [1:0]         s_hold_r;
   logic [1:0]         t_hold_r;

   logic q_beat_s;
   logic t_beat_s;
   logic out_beat_s;
   logic q_last_s;
   logic t_last_s;
   logic o_last_s;

   // Handshake beats: the readies are decoded from the state register only,
   // so the valids reach the array enables but never feed back into a ready.
   assign q_beat_s   = q_valid & (state_r == LOAD);
   assign t_beat_s   = t_valid & (state_r == STREAM);
   assign out_beat_s = arr_valid_out & ((state_r == STREAM) | (state_r == DRAIN));
   assign q_last_s   = q_beat_s & (q_cnt_r == Q_LAST);
   // len_r is at least 1 whenever STREAM/DRAIN are reachable, so len_r-1 is safe.
   assign t_last_s   = t_beat_s & (t_cnt_r == (len_r - LEN_W'(1)));
   assign o_last_s   = out_beat_s & (o_cnt_r == (len_r - LEN_W'(1)));

   assign q_ready    = (state_r == LOAD);
   assign t_ready    = (state_r == STREAM);
   assign res_valid  = (state_r == DONE);
   assign busy       = (state_r != IDLE);
   assign res_score  = max_r;
   assign arr_s_load = q_beat_s;
   assign arr_valid  = t_beat_s;
   // Symbols pass straight through on a beat and otherwise hold the last beat.
   assign arr_s      = q_beat_s ? q_sym : s_hold_r;
   assign arr_t      = t_beat_s ? t_sym : t_hold_r;
   assign arr_v      = '0;
   assign arr_f      = '0;
   assign arr_max    = '0;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; output completion takes priority over the stream end.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            if (q_last_s) begin
               if (len_r == LEN_W'(0)) begin
                  state_s = DONE;
               end else begin
                  state_s = STREAM;
               end
            end else begin
               state_s = LOAD;
            end
         end
         STREAM: begin
            if (o_last_s) begin
               state_s = DONE;
            end else if (t_last_s) begin
               state_s = DRAIN;
            end else begin
               state_s = STREAM;
            end
         end
         DRAIN: begin
            if (o_last_s) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Run bookkeeping: length latch, beat counters, running max, symbol holds.
   // Counters stop on their final beat so a maximal len_r never wraps them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_r    <= '0;
         q_cnt_r  <= '0;
         t_cnt_r  <= '0;
         o_cnt_r  <= '0;
         max_r    <= '0;
         s_hold_r <= 2'b00;
         t_hold_r <= 2'b00;
      end else if ((state_r == IDLE) && start) begin
         len_r   <= t_len;
         q_cnt_r <= '0;
         t_cnt_r <= '0;
         o_cnt_r <= '0;
         max_r   <= '0;
      end else begin
         if (q_beat_s) begin
            s_hold_r <= q_sym;
            if (!q_last_s) begin
               q_cnt_r <= q_cnt_r + Q_W'(1);
            end
         end
         if (t_beat_s) begin
            t_hold_r <= t_sym;
            if (!t_last_s) begin
               t_cnt_r <= t_cnt_r + LEN_W'(1);
            end
         end
         if (out_beat_s) begin
            if (!o_last_s) begin
               o_cnt_r <= o_cnt_r + LEN_W'(1);
            end
            if (arr_max_out > max_r) begin
               max_r <= arr_max_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Testbench for sw_array_ctrl: a behavioural array model with depth PE_LENGTH
// returns a per-test scripted max score for every target beat; expected
// scores go onto a scoreboard queue at run start and are popped at result.
module tb_sw_array_ctrl;

   localparam int PE_LENGTH = 128;
   localparam int LEN_W     = 12;
   localparam int SCORE_W   = 12;
   localparam int D         = PE_LENGTH;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [LEN_W-1:0]   t_len = '0;
   logic               q_valid = 1'b0;
   logic               q_ready;
   logic [1:0]         q_sym = 2'b00;
   logic               t_valid = 1'b0;
   logic               t_ready;
   logic [1:0]         t_sym = 2'b00;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic [SCORE_W-1:0] res_score;
   logic               busy;
   logic [1:0]         arr_s;
   logic               arr_s_load;
   logic [1:0]         arr_t;
   logic               arr_valid;
   logic [SCORE_W-1:0] arr_v;
   logic [SCORE_W-1:0] arr_f;
   logic [SCORE_W-1:0] arr_max;
   logic               arr_valid_out;
   logic [SCORE_W-1:0] arr_max_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int s_cnt = 0;
   int v_cnt = 0;
   logic [1:0] got_s[$];
   logic [1:0] got_t[$];
   int exp_q[$];

   logic [1:0]         qsyms [PE_LENGTH];
   logic [1:0]         tsyms [4096];
   logic [SCORE_W-1:0] script [4096];

   logic [D-1:0]       vpipe;
   logic [SCORE_W-1:0] mpipe [D];
   int                 bidx;

   sw_array_ctrl #(.PE_LENGTH(PE_LENGTH), .LEN_W(LEN_W), .SCORE_W(SCORE_W)) dut (
      .clk(clk), .rst(rst), .start(start), .t_len(t_len),
      .q_valid(q_valid), .q_ready(q_ready), .q_sym(q_sym),
      .t_valid(t_valid), .t_ready(t_ready), .t_sym(t_sym),
      .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
      .busy(busy), .arr_s(arr_s), .arr_s_load(arr_s_load), .arr_t(arr_t),
      .arr_valid(arr_valid), .arr_v(arr_v), .arr_f(arr_f), .arr_max(arr_max),
      .arr_valid_out(arr_valid_out), .arr_max_out(arr_max_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Array model: each accepted beat emerges D cycles later with its scripted max.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         vpipe <= '0;
         for (int i = 0; i < D; i++) mpipe[i] <= '0;
         bidx <= 0;
      end else begin
         vpipe    <= {vpipe[D-2:0], arr_valid};
         mpipe[0] <= script[bidx];
         for (int i = 1; i < D; i++) mpipe[i] <= mpipe[i-1];
         if (start && !busy) bidx <= 0;
         else if (arr_valid) bidx <= bidx + 1;
      end
   end
   assign arr_valid_out = vpipe[D-1];
   assign arr_max_out   = arr_valid_out ? mpipe[D-1] : '0;

   // Monitor of array-side load and stream beats.
   always @(posedge clk) begin
      if (arr_s_load) begin
         s_cnt <= s_cnt + 1;
         got_s.push_back(arr_s);
      end
      if (arr_valid) begin
         v_cnt <= v_cnt + 1;
         got_t.push_back(arr_t);
      end
   end

   // Called at a negedge; returns at a negedge after the last target beat.
   task automatic drive_run(input int len, input bit stall, input int tbeats);
      int i;
      int guard;
      start = 1'b1;
      t_len = LEN_W'(len);
      start_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      i = 0;
      guard = 0;
      while (i < PE_LENGTH && guard < 5000) begin
         q_valid = (stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         q_sym = qsyms[i];
         if (q_valid && q_ready) i++;
         @(negedge clk);
         guard++;
      end
      q_valid = 1'b0;
      i = 0;
      while (i < tbeats && guard < 20000) begin
         t_valid = (stall && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         t_sym = tsyms[i];
         if (t_valid && t_ready) i++;
         @(negedge clk);
         guard++;
      end
      t_valid = 1'b0;
      n_checks++;
      if (guard >= 20000) begin
         n_errors++;
         $display("FAIL drive_timeout got %0d beats want %0d", i, tbeats);
      end
   endtask

   task automatic wait_res(output int lat, output bit ok);
      int g;
      g = 0;
      while (!res_valid && g < 3000) begin
         @(negedge clk);
         g++;
      end
      ok = res_valid;
      lat = cyc - start_cyc + 1;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] outs;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      outs = {busy, q_ready, t_ready, res_valid, arr_s_load, arr_valid, arr_s, arr_t,
              res_score, arr_v, arr_f, arr_max};
      n_checks++;
      if (outs !== 64'd0) begin
         n_errors++;
         $display("FAIL reset_outputs got %h want 0", outs);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release_busy got %b want 0", busy);
      end
   endtask

   task automatic test_exact_match();
      int lat, exp_v, sb, vb;
      bit ok;
      for (int i = 0; i < PE_LENGTH; i++) qsyms[i] = 2'd0;
      for (int i = 0; i < 128; i++) begin
         tsyms[i] = 2'd0;
         script[i] = SCORE_W'(2 * (i + 1));
      end
      exp_q.push_back(256);
      sb = s_cnt; vb = v_cnt;
      drive_run(128, 1'b0, 128);
      wait_res(lat, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (!ok || res_score !== SCORE_W'(exp_v)) begin
         n_errors++;
         $display("FAIL exact_score got %0d want %0d", res_score, exp_v);
      end
      n_checks++;
      if (lat != PE_LENGTH + 128 + D + 1) begin
         n_errors++;
         $display("FAIL exact_latency got %0d want %0d", lat, PE_LENGTH + 128 + D + 1);
      end
      n_checks++;
      if (s_cnt - sb != PE_LENGTH || v_cnt - vb != 128) begin
         n_errors++;
         $display("FAIL exact_beats got %0d/%0d want 128/128", s_cnt - sb, v_cnt - vb);
      end
      handshake();
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL exact_idle got busy %b valid %b want 0 0", busy, res_valid);
      end
   endtask

   task automatic test_zero_len();
      int lat, exp_v, sb, vb;
      bit ok;
      for (int i = 0; i < 16; i++) script[i] = SCORE_W'(100 + i);
      exp_q.push_back(0);
      sb = s_cnt; vb = v_cnt;
      drive_run(0, 1'b0, 0);
      wait_res(lat, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (!ok || res_score !== SCORE_W'(exp_v)) begin
         n_errors++;
         $display("FAIL zero_score got %0d want %0d", res_score, exp_v);
      end
      n_checks++;
      if (s_cnt - sb != PE_LENGTH || v_cnt - vb != 0) begin
         n_errors++;
         $display("FAIL zero_beats got %0d/%0d want 128/0", s_cnt - sb, v_cnt - vb);
      end
      n_checks++;
      if (lat != PE_LENGTH + 1) begin
         n_errors++;
         $display("FAIL zero_latency got %0d want %0d", lat, PE_LENGTH + 1);
      end
      handshake();
   endtask

   task automatic test_max_tracking();
      int lat, exp_v;
      bit ok;
      script[0] = 12'd5; script[1] = 12'd40; script[2] = 12'd12;
      script[3] = 12'd40; script[4] = 12'd7;
      for (int i = 5; i < 16; i++) script[i] = 12'd999;
      for (int i = 0; i < 5; i++) tsyms[i] = 2'(i);
      exp_q.push_back(40);
      drive_run(5, 1'b0, 5);
      wait_res(lat, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (!ok || res_score !== SCORE_W'(exp_v)) begin
         n_errors++;
         $display("FAIL max_score got %0d want %0d", res_score, exp_v);
      end
      n_checks++;
      if (lat != 1 + PE_LENGTH + 5 + (D - 1) + 1) begin
         n_errors++;
         $display("FAIL max_latency got %0d want %0d", lat, 1 + PE_LENGTH + 5 + (D - 1) + 1);
      end
      handshake();
   endtask

   task automatic test_stalls();
      int lat, exp_v, score_ns, sb, vb, qb, tb, mism;
      bit ok;
      exp_v = 0;
      for (int i = 0; i < PE_LENGTH; i++) qsyms[i] = 2'($urandom_range(0, 3));
      for (int i = 0; i < 60; i++) begin
         tsyms[i] = 2'($urandom_range(0, 3));
         script[i] = SCORE_W'($urandom_range(0, 4000));
         if (int'(script[i]) > exp_v) exp_v = int'(script[i]);
      end
      exp_q.push_back(exp_v);
      drive_run(60, 1'b0, 60);
      wait_res(lat, ok);
      score_ns = int'(res_score);
      n_checks++;
      if (!ok || score_ns != exp_q.pop_front()) begin
         n_errors++;
         $display("FAIL nostall_score got %0d want %0d", score_ns, exp_v);
      end
      handshake();
      exp_q.push_back(exp_v);
      sb = s_cnt; vb = v_cnt; qb = got_s.size(); tb = got_t.size();
      drive_run(60, 1'b1, 60);
      wait_res(lat, ok);
      n_checks++;
      if (!ok || int'(res_score) != exp_q.pop_front() || int'(res_score) != score_ns) begin
         n_errors++;
         $display("FAIL stall_score got %0d want %0d", res_score, score_ns);
      end
      n_checks++;
      if (s_cnt - sb != PE_LENGTH || v_cnt - vb != 60) begin
         n_errors++;
         $display("FAIL stall_beats got %0d/%0d want 128/60", s_cnt - sb, v_cnt - vb);
      end
      mism = 0;
      for (int i = 0; i < PE_LENGTH; i++) if (got_s[qb + i] !== qsyms[i]) mism++;
      for (int i = 0; i < 60; i++) if (got_t[tb + i] !== tsyms[i]) mism++;
      n_checks++;
      if (mism != 0) begin
         n_errors++;
         $display("FAIL stall_symbols got %0d wrong want 0", mism);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int lat, exp_v, bad;
      bit ok;
      exp_v = 0;
      for (int i = 0; i < 10; i++) begin
         script[i] = SCORE_W'(50 + 17 * ((i * 7) % 10));
         if (int'(script[i]) > exp_v) exp_v = int'(script[i]);
      end
      exp_q.push_back(exp_v);
      drive_run(10, 1'b0, 10);
      wait_res(lat, ok);
      exp_v = exp_q.pop_front();
      bad = ok ? 0 : 1;
      for (int k = 0; k < 20; k++) begin
         start = (k == 5) ? 1'b1 : 1'b0;
         t_len = 12'd7;
         @(negedge clk);
         if (res_score !== SCORE_W'(exp_v) || busy !== 1'b1 || res_valid !== 1'b1) bad++;
      end
      start = 1'b0;
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL hold_result got %0d bad cycles (score %0d) want 0 (score %0d)",
                  bad, res_score, exp_v);
      end
      handshake();
      n_checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL hold_release got busy %b valid %b want 0 0", busy, res_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit ok;
      for (int i = 0; i < 10; i++) script[i] = SCORE_W'(300 - 20 * i);
      exp_q.push_back(300);
      drive_run(10, 1'b0, 10);
      wait_res(lat, ok);
      n_checks++;
      if (!ok || res_score !== SCORE_W'(exp_q.pop_front())) begin
         n_errors++;
         $display("FAIL b2b_score got %0d want 300", res_score);
      end
      n_checks++;
      if (lat != 1 + PE_LENGTH + 10 + (D - 1) + 1) begin
         n_errors++;
         $display("FAIL b2b_latency got %0d want %0d", lat, 1 + PE_LENGTH + 10 + (D - 1) + 1);
      end
      handshake();
   endtask

   task automatic test_reset_midstream();
      int lat, exp_v;
      bit ok;
      logic [63:0] outs;
      for (int i = 0; i < 100; i++) script[i] = SCORE_W'(900);
      drive_run(100, 1'b0, 50);
      rst = 1'b0;
      #1;
      outs = {busy, q_ready, t_ready, res_valid, arr_s_load, arr_valid, arr_s, arr_t,
              res_score, arr_v, arr_f, arr_max};
      n_checks++;
      if (outs !== 64'd0) begin
         n_errors++;
         $display("FAIL midreset_outputs got %h want 0", outs);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_v = 0;
      for (int i = 0; i < 20; i++) begin
         script[i] = SCORE_W'($urandom_range(0, 800));
         if (int'(script[i]) > exp_v) exp_v = int'(script[i]);
      end
      exp_q.push_back(exp_v);
      drive_run(20, 1'b0, 20);
      wait_res(lat, ok);
      n_checks++;
      if (!ok || int'(res_score) != exp_q.pop_front()) begin
         n_errors++;
         $display("FAIL midreset_rerun got %0d want %0d", res_score, exp_v);
      end
      handshake();
   endtask

   initial begin
      test_reset();
      test_exact_match();
      test_zero_len();
      test_max_tracking();
      test_stalls();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got time %0t want finish", $time);
      $fatal(1, "timeout");
   end

endmodule
